// File: rtl/cpu_result_capture_if.sv
// Bus between the result-capture block, the CPU data-memory write port it snoops,
// and the downstream consumer that drains captured stores over valid/ready.
interface cpu_result_capture_if #(
    parameter int NB_DATA    = 16,
    parameter int NB_ADDRESS = 11,
    parameter int DEPTH      = 8,
    parameter int NB_CYCLES  = 32
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  i_wr_pc;
    logic                  i_wr_ram;
    logic [NB_ADDRESS-1:0] i_dm_address;
    logic [NB_DATA-1:0]    i_dm_data;
    logic                  i_ready;
    logic                  o_valid;
    logic [NB_ADDRESS-1:0] o_addr;
    logic [NB_DATA-1:0]    o_data;
    logic                  o_last;
    logic                  o_halted;
    logic                  o_done;
    logic                  o_overflow;
    logic [CW-1:0]         o_count;
    logic [NB_CYCLES-1:0]  o_cycles;

    modport slave (
        input  i_wr_pc, i_wr_ram, i_dm_address, i_dm_data, i_ready,
        output o_valid, o_addr, o_data, o_last, o_halted, o_done,
               o_overflow, o_count, o_cycles
    );

    modport master (
        output i_wr_pc, i_wr_ram, i_dm_address, i_dm_data, i_ready,
        input  o_valid, o_addr, o_data, o_last, o_halted, o_done,
               o_overflow, o_count, o_cycles
    );
endinterface

// File: rtl/cpu_result_capture.sv
// Captures every CPU data-memory store into a FIFO, detects halt and counts cycles,
// then drains the records to a consumer. Define CAPTURE_DEDUP_EN to drop repeated stores.
module cpu_result_capture #(
    parameter int NB_DATA     = 16,
    parameter int NB_ADDRESS  = 11,
    parameter int DEPTH       = 8,
    parameter int NB_CYCLES   = 32,
    parameter int HALT_CYCLES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    cpu_result_capture_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = $clog2(HALT_CYCLES + 1);
    localparam int EW = NB_ADDRESS + NB_DATA;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    logic [EW-1:0]        mem_q [DEPTH];
    state_t               state_q, state_d;
    logic [PW-1:0]        wrPtr_q, wrPtr_d;
    logic [PW-1:0]        rdPtr_q, rdPtr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [NB_CYCLES-1:0] cycles_q, cycles_d;
    logic [RW-1:0]        runCnt_q, runCnt_d;
    logic                 halted_q, halted_d;
    logic                 overflow_q, overflow_d;

    logic          syncReset;
    logic          pushReq, push, pop, full, haltNow, isDup, headValid;
    logic [EW-1:0] storeEntry, headEntry;

    assign syncReset  = i_reset | i_clear;
    assign storeEntry = {bus.i_dm_address, bus.i_dm_data};
    assign headValid  = (count_q != '0);
    assign full       = (count_q == CW'(DEPTH));
    assign pop        = headValid & bus.i_ready;
    assign pushReq    = (state_q == RUN) & bus.i_wr_ram & ~isDup;
    // A full FIFO still accepts a store when the head leaves in the same cycle
    assign push       = pushReq & (~full | pop);
    assign haltNow    = (state_q == RUN) & ~bus.i_wr_pc & (runCnt_q == RW'(HALT_CYCLES - 1));

`ifdef CAPTURE_DEDUP_EN
    logic [EW-1:0] lastEntry_q, lastEntry_d;
    logic          lastValid_q, lastValid_d;

    assign isDup = lastValid_q & (lastEntry_q == storeEntry);

    always_comb begin
        lastEntry_d = lastEntry_q;
        lastValid_d = lastValid_q;
        if (push) begin
            lastEntry_d = storeEntry;
            lastValid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (syncReset) begin
            lastEntry_q <= '0;
            lastValid_q <= 1'b0;
        end else begin
            lastEntry_q <= lastEntry_d;
            lastValid_q <= lastValid_d;
        end
    end
`else
    assign isDup = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        cycles_d   = cycles_q;
        runCnt_d   = runCnt_q;
        halted_d   = 1'b0;
        overflow_d = overflow_q;

        if (pushReq & full & ~pop) overflow_d = 1'b1;
        if (push) wrPtr_d = wrPtr_q + PW'(1);
        if (pop)  rdPtr_d = rdPtr_q + PW'(1);

        case (state_q)
            RUN: begin
                runCnt_d = bus.i_wr_pc ? '0 : runCnt_q + RW'(1);
                // The halt-declaring cycle is not counted, so o_cycles stops at the halt run's start
                if (!haltNow && (cycles_q != '1)) cycles_d = cycles_q + NB_CYCLES'(1);
                if (haltNow) begin
                    halted_d = 1'b1;
                    state_d  = (count_d == '0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (count_d == '0) state_d = DONE;
            end
            DONE: begin
                state_d = DONE;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (syncReset) begin
            state_q    <= RUN;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            cycles_q   <= '0;
            runCnt_q   <= '0;
            halted_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            cycles_q   <= cycles_d;
            runCnt_q   <= runCnt_d;
            halted_q   <= halted_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wrPtr_q] <= storeEntry;
    end

    // Storage is never reset, so the head is masked to zero while the FIFO is empty
    assign headEntry      = headValid ? mem_q[rdPtr_q] : '0;
    assign bus.o_valid    = headValid;
    assign bus.o_addr     = headEntry[EW-1:NB_DATA];
    assign bus.o_data     = headEntry[NB_DATA-1:0];
    assign bus.o_last     = (state_q == DRAIN) & (count_q == CW'(1));
    assign bus.o_halted   = halted_q;
    assign bus.o_done     = (state_q == DONE);
    assign bus.o_overflow = overflow_q;
    assign bus.o_count    = count_q;
    assign bus.o_cycles   = cycles_q;
endmodule

// File: tb/tb_cpu_result_capture.sv
// Self-checking bench for cpu_result_capture: directed scenarios plus random traffic,
// every cycle compared against a queue-based behavioural model.
module tb_cpu_result_capture;
    localparam int NB_DATA     = 16;
    localparam int NB_ADDRESS  = 11;
    localparam int DEPTH       = 8;
    localparam int NB_CYCLES   = 32;
    localparam int HALT_CYCLES = 2;
    localparam int EW          = NB_ADDRESS + NB_DATA;
    localparam int CW          = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;

    int compareCount  = 0;
    int mismatchCount = 0;

    cpu_result_capture_if #(
        .NB_DATA(NB_DATA), .NB_ADDRESS(NB_ADDRESS), .DEPTH(DEPTH), .NB_CYCLES(NB_CYCLES)
    ) bus ();

    cpu_result_capture #(
        .NB_DATA(NB_DATA), .NB_ADDRESS(NB_ADDRESS), .DEPTH(DEPTH),
        .NB_CYCLES(NB_CYCLES), .HALT_CYCLES(HALT_CYCLES)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_clear(clr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: a queue of captured records plus a few flags
    logic [EW-1:0]        mQ[$];
    logic                 mDeclared, mPulse, mOverflow, mLastValid;
    logic [EW-1:0]        mLastEntry;
    logic [NB_CYCLES-1:0] mCycles;
    int                   mLowRun;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        logic [EW-1:0] head;
        head = (mQ.size() > 0) ? mQ[0] : '0;
        checkOutput("valid",    64'(bus.o_valid),    64'(mQ.size() > 0));
        checkOutput("addr",     64'(bus.o_addr),     64'(head[EW-1:NB_DATA]));
        checkOutput("data",     64'(bus.o_data),     64'(head[NB_DATA-1:0]));
        checkOutput("last",     64'(bus.o_last),     64'(mDeclared && mQ.size() == 1));
        checkOutput("halted",   64'(bus.o_halted),   64'(mPulse));
        checkOutput("done",     64'(bus.o_done),     64'(mDeclared && mQ.size() == 0));
        checkOutput("overflow", 64'(bus.o_overflow), 64'(mOverflow));
        checkOutput("count",    64'(bus.o_count),    64'(mQ.size()));
        checkOutput("cycles",   64'(bus.o_cycles),   64'(mCycles));
    endtask

    task automatic applyStimulus(input logic rstIn, input logic clrIn, input logic wrPc,
                                 input logic wrRam, input logic [NB_ADDRESS-1:0] a,
                                 input logic [NB_DATA-1:0] d, input logic rdy);
        logic popNow, haltNow, dup;
        rst              = rstIn;
        clr              = clrIn;
        bus.i_wr_pc      = wrPc;
        bus.i_wr_ram     = wrRam;
        bus.i_dm_address = a;
        bus.i_dm_data    = d;
        bus.i_ready      = rdy;
        popNow  = (mQ.size() > 0) && rdy;
        haltNow = 1'b0;
        @(posedge clk);
        #1;
        if (rstIn || clrIn) begin
            mQ.delete();
            mDeclared  = 1'b0;
            mPulse     = 1'b0;
            mOverflow  = 1'b0;
            mCycles    = '0;
            mLowRun    = 0;
            mLastValid = 1'b0;
            mLastEntry = '0;
        end else begin
            if (!mDeclared) begin
                haltNow = !wrPc && (mLowRun + 1 >= HALT_CYCLES);
                mLowRun = wrPc ? 0 : mLowRun + 1;
                if (!haltNow && mCycles != '1) mCycles = mCycles + 1'b1;
            end
            if (popNow) void'(mQ.pop_front());
            if (!mDeclared && wrRam) begin
                dup = 1'b0;
`ifdef CAPTURE_DEDUP_EN
                dup = mLastValid && (mLastEntry == {a, d});
`endif
                if (!dup) begin
                    if (mQ.size() < DEPTH) begin
                        mQ.push_back({a, d});
                        mLastEntry = {a, d};
                        mLastValid = 1'b1;
                    end else begin
                        mOverflow = 1'b1;
                    end
                end
            end
            mPulse    = haltNow;
            mDeclared = mDeclared | haltNow;
        end
        checkAll();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, rdy);
    endtask

    initial begin
        int readyBias;
        bus.i_wr_pc = 1'b1; bus.i_wr_ram = 1'b0; bus.i_dm_address = '0;
        bus.i_dm_data = '0; bus.i_ready = 1'b0;
        mQ.delete(); mDeclared = 1'b0; mPulse = 1'b0; mOverflow = 1'b0;
        mCycles = '0; mLowRun = 0; mLastValid = 1'b0; mLastEntry = '0;

        $display("[TB] reset state");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);

        $display("[TB] basic capture");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 11'h003, 16'h00AA, 1'b1);
        checkOutput("basic_valid1", 64'(bus.o_valid), 64'd1);
        checkOutput("basic_data1",  64'(bus.o_data),  64'h00AA);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 11'h004, 16'h0055, 1'b1);
        checkOutput("basic_addr2",  64'(bus.o_addr),  64'h004);
        idle(1, 1'b1);
        checkOutput("basic_empty",  64'(bus.o_count), 64'd0);

        $display("[TB] halt with drain");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        for (int c = 0; c < 20; c++)
            applyStimulus(1'b0, 1'b0, 1'b1, (c == 2 || c == 5 || c == 9), 11'(c), 16'(c * 3), 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        checkOutput("halt_early", 64'(bus.o_halted), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        checkOutput("halt_pulse",  64'(bus.o_halted), 64'd1);
        checkOutput("halt_cycles", 64'(bus.o_cycles), 64'd21);
        idle(1, 1'b0);
        checkOutput("halt_once",   64'(bus.o_halted), 64'd0);
        checkOutput("halt_last0",  64'(bus.o_last),   64'd0);
        for (int i = 0; i < 3; i++) begin
            if (bus.o_count == CW'(1)) checkOutput("halt_last3", 64'(bus.o_last), 64'd1);
            idle(1, 1'b1);
        end
        checkOutput("halt_done", 64'(bus.o_done), 64'd1);

        $display("[TB] overflow");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 11'(16 + i), 16'(16'hA000 + i), 1'b0);
        checkOutput("ovf_count", 64'(bus.o_count),    64'd8);
        checkOutput("ovf_flag",  64'(bus.o_overflow), 64'd1);
        for (int i = 0; i < 8; i++) begin
            checkOutput("ovf_order", 64'(bus.o_addr), 64'(16 + i));
            idle(1, 1'b1);
        end

        $display("[TB] full push plus pop");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 11'(i), 16'(16'h0100 + i), 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 11'h07F, 16'hBEEF, 1'b1);
        checkOutput("fpp_count", 64'(bus.o_count),    64'd8);
        checkOutput("fpp_ovf",   64'(bus.o_overflow), 64'd0);

        $display("[TB] glitch rejection and clear");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        checkOutput("glitch_nohalt", 64'(bus.o_halted), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        checkOutput("drain_halted", 64'(bus.o_halted), 64'd1);
        idle(2, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        checkOutput("clear_count", 64'(bus.o_count),  64'd0);
        checkOutput("clear_last",  64'(bus.o_last),   64'd0);
        checkOutput("clear_cyc",   64'(bus.o_cycles), 64'd0);

        $display("[TB] dedup");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 11'h010, (i == 2) ? 16'h1235 : 16'h1234, 1'b0);
`ifdef CAPTURE_DEDUP_EN
        checkOutput("dedup_count", 64'(bus.o_count), 64'd2);
`else
        checkOutput("dedup_count", 64'(bus.o_count), 64'd3);
`endif

        $display("[TB] random traffic");
        readyBias = 2;
        for (int n = 0; n < 4000; n++) begin
            if (n % 100 == 0) readyBias = int'($urandom_range(0, 4));
            applyStimulus(($urandom % 700) == 0, ($urandom % 80) == 0, ($urandom % 6) != 0,
                          $urandom_range(0, 1) == 1, 11'($urandom_range(0, 3)),
                          (($urandom % 2) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom),
                          int'($urandom_range(0, 3)) < readyBias);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule
